// File: rtl/muldiv_seq_unit.sv
//------------------------------------------------------------------------------
// Module   : muldiv_seq_unit
// Brief    : Iterative RV32M multiply/divide unit, one bit per cycle, tagged.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_seq_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int              CNT_W      = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(1);
    localparam logic [XLEN-1:0]  C_MIN      = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  C_ONES     = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [2:0]            r_op;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic [2*XLEN-1:0]     r_acc;
    logic [XLEN-1:0]       r_b;

    logic                  w_accept;
    logic                  w_is_div;
    logic                  w_rs1_signed;
    logic                  w_rs2_signed;
    logic                  w_rs1_neg;
    logic                  w_rs2_neg;
    logic [XLEN-1:0]       w_mag1;
    logic [XLEN-1:0]       w_mag2;
    logic                  w_div_zero;
    logic                  w_ovf;
    logic                  w_special;
    logic [XLEN-1:0]       w_special_result;

    logic [XLEN:0]         w_mul_sum;
    logic [2*XLEN-1:0]     w_mul_nxt;
    logic [XLEN:0]         w_rem_sh;
    logic                  w_rem_ge;
    logic [XLEN-1:0]       w_diff;
    logic [2*XLEN-1:0]     w_div_nxt;
    logic [2*XLEN-1:0]     w_acc_nxt;
    logic [2*XLEN-1:0]     w_prod;
    logic [XLEN-1:0]       w_quo;
    logic [XLEN-1:0]       w_rem;
    logic [XLEN-1:0]       w_calc_result;

    // Operand decode at the accept boundary
    assign w_accept     = in_valid && in_ready && !flush;
    assign w_is_div     = in_op[2];
    assign w_rs1_signed = (in_op == 3'b001) || (in_op == 3'b010) ||
                          (in_op == 3'b100) || (in_op == 3'b110);
    assign w_rs2_signed = (in_op == 3'b001) || (in_op == 3'b100) || (in_op == 3'b110);
    assign w_rs1_neg    = w_rs1_signed && in_rs1[XLEN-1];
    assign w_rs2_neg    = w_rs2_signed && in_rs2[XLEN-1];
    assign w_mag1       = w_rs1_neg ? (-in_rs1) : in_rs1;
    assign w_mag2       = w_rs2_neg ? (-in_rs2) : in_rs2;
    assign w_div_zero   = w_is_div && (in_rs2 == '0);
    assign w_ovf        = ((in_op == 3'b100) || (in_op == 3'b110)) &&
                          (in_rs1 == C_MIN) && (in_rs2 == C_ONES);
    assign w_special    = w_div_zero || w_ovf;

    always_comb begin
        w_special_result = '0;
        if (w_div_zero) begin
            w_special_result = in_op[1] ? in_rs1 : C_ONES;
        end else if (w_ovf) begin
            w_special_result = in_op[1] ? '0 : in_rs1;
        end
    end

    // Shift-add: multiplier sits in the low half and is consumed LSB first
    assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_nxt = {w_mul_sum, r_acc[XLEN-1:1]};

    // Restoring division: {remainder, dividend/quotient} shifts left each step
    assign w_rem_sh  = r_acc[2*XLEN-1:XLEN-1];
    assign w_rem_ge  = (w_rem_sh >= {1'b0, r_b});
    assign w_diff    = w_rem_sh[XLEN-1:0] - r_b;
    assign w_div_nxt = w_rem_ge ? {w_diff, r_acc[XLEN-2:0], 1'b1}
                                : {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
    assign w_acc_nxt = r_op[2] ? w_div_nxt : w_mul_nxt;

    assign w_prod = r_neg_q ? (-w_acc_nxt) : w_acc_nxt;
    assign w_quo  = r_neg_q ? (-w_acc_nxt[XLEN-1:0]) : w_acc_nxt[XLEN-1:0];
    assign w_rem  = r_neg_r ? (-w_acc_nxt[2*XLEN-1:XLEN]) : w_acc_nxt[2*XLEN-1:XLEN];

    always_comb begin
        w_calc_result = '0;
        case (r_op)
            3'b000:                 w_calc_result = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_calc_result = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_calc_result = w_quo;
            default:                w_calc_result = w_rem;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_op       <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_acc      <= '0;
            r_b        <= '0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_accept) begin
                r_op    <= in_op;
                out_tag <= in_tag;
                r_neg_q <= w_rs1_neg ^ w_rs2_neg;
                r_neg_r <= w_rs1_neg;
                if (w_special) begin
                    out_result <= w_special_result;
                end else begin
                    r_cnt <= C_CNT_INIT;
                    r_acc <= w_is_div ? {{XLEN{1'b0}}, w_mag1} : {{XLEN{1'b0}}, w_mag2};
                    r_b   <= w_is_div ? w_mag2 : w_mag1;
                end
            end
        end else if (r_state == S_CALC) begin
            if (flush) begin
                r_cnt <= '0;
            end else begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt - C_CNT_LAST;
                if (r_cnt == C_CNT_LAST) begin
                    out_result <= w_calc_result;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_muldiv_seq_unit
// Brief    : Self-checking bench for muldiv_seq_unit (XLEN=32).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_muldiv_seq_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [4:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        busy;

    int total = 0;
    int bad   = 0;

    muldiv_seq_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model straight from the RV32M arithmetic rules
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        logic [63:0] p;
        int          da;
        int          db;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        da = $signed(a);
        db = $signed(b);
        p  = '0;
        case (op)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return da / db;
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return da % db;
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op[2] && b == 32'd0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // lat = cycle offset from the accept cycle to first out_valid (N+lat)
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input bit consume,
                          output logic [31:0] res, output logic [4:0] tg, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_tag   = tag;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_rs1   = $urandom;
        in_rs2   = $urandom;
        in_tag   = 5'($urandom_range(0, 31));
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = out_result;
        tg  = out_tag;
        if (consume && out_valid) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] res;
        logic [4:0]  tg;
        int          lat;
        logic [31:0] exp;
        int          seen;

        reset_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0;
        in_tag = '0; flush = 1'b0; out_ready = 1'b1;

        vecs[0]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'h0000_0001, 33};
        vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 33};
        vecs[2]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 33};
        vecs[3]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, 33};
        vecs[4]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd5,  32'h4000_0000, 33};
        vecs[5]  = '{3'd0, 32'h0000_FFFF, 32'h0001_0001, 5'd17, 32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFD, 33};
        vecs[7]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFF, 33};
        vecs[8]  = '{3'd5, 32'd7,         32'd2,         5'd8,  32'd3,         33};
        vecs[9]  = '{3'd7, 32'd7,         32'd2,         5'd9,  32'd1,         33};
        vecs[10] = '{3'd5, 32'd5,         32'd0,         5'd10, 32'hFFFF_FFFF, 1};
        vecs[11] = '{3'd6, 32'd5,         32'd0,         5'd11, 32'd5,         1};
        vecs[12] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1};
        vecs[13] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0,         1};
        vecs[14] = '{3'd5, 32'hFFFF_FFFF, 32'd1,         5'd14, 32'hFFFF_FFFF, 33};
        vecs[15] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 33};

        #12;
        check("reset in_ready",   32'(in_ready),  32'd1);
        check("reset busy",       32'(busy),      32'd0);
        check("reset out_valid",  32'(out_valid), 32'd0);
        check("reset out_result", out_result,     32'd0);
        check("reset out_tag",    32'(out_tag),   32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, 1'b1, res, tg, lat);
            check($sformatf("vec%0d result", i),  res,         vecs[i].exp);
            check($sformatf("vec%0d latency", i), 32'(lat),    32'(vecs[i].lat));
            check($sformatf("vec%0d tag", i),     32'(tg),     32'(vecs[i].tag));
            check($sformatf("vec%0d ready", i),   32'(in_ready), 32'd1);
        end

        // Backpressure: DONE held for 5 cycles
        out_ready = 1'b0;
        exp = ref_model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
        run_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd23, 1'b0, res, tg, lat);
        check("bp result", res, exp);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp hold result %0d", k), out_result,      exp);
            check($sformatf("bp hold tag %0d", k),    32'(out_tag),    32'd23);
            check($sformatf("bp in_ready %0d", k),    32'(in_ready),   32'd0);
            check($sformatf("bp out_valid %0d", k),   32'(out_valid),  32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release in_ready", 32'(in_ready), 32'd1);
        run_op(3'd0, 32'h0001_2345, 32'h0000_6789, 5'd29, 1'b1, res, tg, lat);
        check("b2b result",  res,      ref_model(3'd0, 32'h0001_2345, 32'h0000_6789));
        check("b2b latency", 32'(lat), 32'd33);
        check("b2b tag",     32'(tg),  32'd29);

        // Flush in the 10th CALC cycle
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd1; in_rs1 = 32'hDEAD_BEEF; in_rs2 = 32'h1357_9BDF; in_tag = 5'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("flush pre busy", 32'(busy), 32'd1);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush busy",      32'(busy),      32'd0);
        check("flush out_valid", 32'(out_valid), 32'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        check("flush no result", 32'(seen), 32'd0);

        // Flush together with a request in IDLE
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; in_op = 3'd5; in_rs1 = 32'd5; in_rs2 = 32'd0; in_tag = 5'd4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        check("flush+valid busy",      32'(busy),      32'd0);
        check("flush+valid out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("flush+valid later", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd0; in_rs1 = 32'h0000_0123; in_rs2 = 32'h0000_0456; in_tag = 5'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async rst out_valid",  32'(out_valid), 32'd0);
        check("async rst busy",       32'(busy),      32'd0);
        check("async rst in_ready",   32'(in_ready),  32'd1);
        check("async rst out_result", out_result,     32'd0);
        check("async rst out_tag",    32'(out_tag),   32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_op(3'd7, 32'd100, 32'd7, 5'd30, 1'b1, res, tg, lat);
        check("post rst result", res, 32'd2);

        // Randomised operations against the model
        for (int i = 0; i < 300; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            logic [4:0]  t;
            int          mode;
            op   = 3'($urandom_range(0, 7));
            a    = $urandom;
            b    = $urandom;
            t    = 5'($urandom_range(0, 31));
            mode = $urandom_range(0, 9);
            if (mode == 0) b = 32'd0;
            else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (mode == 2) b = 32'($urandom_range(1, 15));
            else if (mode == 3) a = 32'($urandom_range(0, 3));
            run_op(op, a, b, t, 1'b1, res, tg, lat);
            check($sformatf("rnd%0d op%0d %h,%h result", i, op, a, b), res, ref_model(op, a, b));
            check($sformatf("rnd%0d latency", i), 32'(lat), 32'(ref_latency(op, a, b)));
            check($sformatf("rnd%0d tag", i),     32'(tg),  32'(t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/muldiv_seq_unit.md
# muldiv_seq_unit

Parametrised, iterative multi-cycle unit for the RV32M multiply/divide operations: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. It sits beside the single-cycle ALU in the execute stage and takes M-extension operations out of the combinational path. Operations are accepted with a valid/ready handshake, computed one bit per cycle, and returned with a tag so the pipeline can stall or retire writeback. RISC-V divide-by-zero and signed-overflow results are produced exactly, as early-out special cases.

## Interface
Parameters:
- XLEN, 32, operand and result width; must be ≥4 and even.
- TAG_W, 5, width of the passthrough tag (destination register index).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  high only in IDLE; an operation is accepted when in_valid && in_ready at a rising edge.
- in_op  in  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- in_rs1  in  XLEN  operand 1 (multiplicand / dividend).
- in_rs2  in  XLEN  operand 2 (multiplier / divisor).
- in_tag  in  TAG_W  returned unchanged on out_tag.
- flush  in  1  synchronous abort of any in-flight operation.
- out_valid  out  1  result available (DONE state).
- out_ready  in  1  consumer accepts the result.
- out_result  out  XLEN  result.
- out_tag  out  TAG_W  tag of the operation.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, CALC, DONE.
- IDLE → CALC on accept. Operands, op, tag and operand signs are latched, and the iteration counter is loaded with XLEN.
- IDLE → DONE on accept of a special case; the final result is latched directly.
- CALC: one iteration per cycle, counter decrements. After the XLEN-th iteration, CALC → DONE with the sign-corrected result registered.
- DONE: out_valid high. out_result and out_tag are held stable until out_valid && out_ready, then DONE → IDLE.
- Signedness:
  - rs1 is signed for MULH, MULHSU, DIV, REM.
  - rs2 is signed for MULH, DIV, REM.
  - Signed operands are converted to magnitudes at accept.
- Multiply: shift-add on magnitudes into a 2·XLEN product. The product is negated if the effective signs differ. MUL returns product[XLEN-1:0]; MULH, MULHSU and MULHU return product[2·XLEN-1:XLEN].
- Divide: restoring shift-subtract on magnitudes.
  - Quotient is negated if sign(rs1) ≠ sign(rs2) (signed ops only).
  - Remainder takes the sign of rs1.
- Special cases (decided at accept, no CALC):
  - Divisor = 0: DIV/DIVU → all ones; REM/REMU → rs1.
  - DIV with rs1 = 1<<(XLEN-1) and rs2 = all ones → rs1; REM with the same operands → 0.
- No early-out for zero multiply operands; latency is data-independent apart from the special cases.
- flush high at a rising edge: state → IDLE, out_valid low next cycle, result discarded. flush takes priority over acceptance in the same cycle; no operation is accepted.
- in_* are ignored while in_ready is low.

## Timing
- Reset (async, while reset_n low): state IDLE, counter 0.
  - in_ready = 1, busy = 0, out_valid = 0.
  - out_result = 0, out_tag = 0.
- Reset asserted mid-operation clears immediately; no result is emitted.
- Accept in cycle N (normal): CALC in cycles N+1..N+XLEN, out_valid first high in cycle N+XLEN+1.
- Accept in cycle N (special case): out_valid high in cycle N+1.
- Handoff in cycle M (out_valid && out_ready): in_ready high in cycle M+1. Minimum issue interval is XLEN+2 cycles normal, 2 cycles special case.
- Backpressure: out_ready low holds DONE indefinitely; outputs stay bit-stable.
- All outputs are registered, except in_ready and busy, which decode state only.

## Test plan
- XLEN=32 multiply, rs1 = rs2 = 0xFFFFFFFF, accept in cycle N:
  - MUL → 0x00000001, MULH → 0x00000000, MULHSU → 0xFFFFFFFF, MULHU → 0xFFFFFFFE.
  - Each result has out_valid first high exactly in cycle N+33.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MUL 0x0000FFFF × 0x00010001 → 0xFFFFFFFF; out_tag equals in_tag (e.g. 5'd17).
- Divide, rs1 = 0xFFFFFFF9 (−7), rs2 = 2:
  - DIV → 0xFFFFFFFD, REM → 0xFFFFFFFF.
  - DIVU 7/2 → 3, REMU 7/2 → 1.
- Special cases, each with out_valid in cycle N+1:
  - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- Backpressure: out_ready held low 5 cycles in DONE → out_result/out_tag unchanged and in_ready low throughout. Release → in_ready high next cycle; a back-to-back op is accepted then.
- Aborts:
  - flush in the 10th CALC cycle → busy = 0 next cycle and no out_valid ever seen.
  - flush together with in_valid in IDLE → nothing accepted.
  - reset_n pulsed low mid-CALC (between edges) → outputs at reset values immediately.
